// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared types and helpers for the system-bus register/memory slave.
//   state_e  - FSM states of sys_bus_regmem (IDLE / WAIT / RESP)
//   op_e     - decoded request kind held in the request register (RD / WR / ERR)
//   log2_f   - ceil(log2(v)) for elaboration-time width calculation
package sys_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_ERR = 2'd2
  } op_e;

  // Wait counter is sized for the largest legal WAIT_CYC.
  localparam int unsigned WCNT_W       = 5;
  localparam int unsigned WAIT_CYC_MAX = 28;

  function automatic int unsigned log2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sys_bus_mem_array.sv
// sys_bus_mem_array: DEPTH x DW storage with per-byte write enables and a
// registered read port.
//   clk, rst  - clock; rst clears only the read register, never the storage
//   addr      - word index shared by write and read
//   wdata, be - write data and byte enables, applied when we is high
//   we        - write strobe
//   re        - capture mem[addr] into rdata
//   clr       - force rdata to zero (error response)
//   rdata     - read register; holds until the next re/clr/rst
module sys_bus_mem_array #(
  parameter int unsigned DW    = 64,
  parameter int unsigned SW    = DW / 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [SW-1:0] be,
  input  logic          we,
  input  logic          re,
  input  logic          clr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < SW; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sys_bus_regmem.sv
// sys_bus_regmem: byte-addressed register/memory slave on the simple system bus.
// Accepts single-cycle sys_wen_i/sys_ren_i pulses in IDLE, waits WAIT_CYC
// cycles (frozen by stall_i), then returns a one-cycle sys_ack_o with read data
// or sys_err_o. Out-of-range addresses and simultaneous wen+ren are errors and
// are acknowledged on the next cycle without touching storage.
//   sys_clk_i, sys_rst_i         - clock, synchronous active-high reset
//   sys_addr_i/wdata_i/sel_i     - request address, write data, byte enables
//   sys_wen_i, sys_ren_i         - request pulses
//   stall_i                      - freezes the wait countdown
//   sys_rdata_o/err_o/ack_o      - response
//   busy_o                       - FSM not in IDLE
//   drop_cnt_o                   - saturating count of pulses ignored while busy
module sys_bus_regmem
  import sys_bus_pkg::*;
#(
  parameter int unsigned   DW        = 64,
  parameter int unsigned   AW        = 32,
  parameter int unsigned   SW        = DW / 8,
  parameter logic [AW-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned   DEPTH     = 256,
  parameter int unsigned   WAIT_CYC  = 2
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic [AW-1:0] sys_addr_i,
  input  logic [DW-1:0] sys_wdata_i,
  input  logic [SW-1:0] sys_sel_i,
  input  logic          sys_wen_i,
  input  logic          sys_ren_i,
  input  logic          stall_i,
  output logic [DW-1:0] sys_rdata_o,
  output logic          sys_err_o,
  output logic          sys_ack_o,
  output logic          busy_o,
  output logic [7:0]    drop_cnt_o
);

  localparam int unsigned   LOG2_SW = log2_f(SW);
  localparam int unsigned   IW      = log2_f(DEPTH);
  localparam logic [AW:0]   SPAN    = (AW+1)'(DEPTH * SW);

  if (WAIT_CYC > WAIT_CYC_MAX) begin : g_bad_wait_cyc
    $error("sys_bus_regmem: WAIT_CYC must not exceed 28");
  end

  state_e              state_q;
  op_e                 req_op_q;
  logic [IW-1:0]       req_idx_q;
  logic [DW-1:0]       req_wdata_q;
  logic [SW-1:0]       req_sel_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic                ack_q;
  logic                err_q;
  logic [7:0]          drop_q;

  // Address decode of the incoming request
  logic [AW-1:0]       off;
  logic                in_range;
  logic                req_any;
  op_e                 op_in;
  logic [IW-1:0]       idx_in;
  logic                unused_ok;

  assign off      = sys_addr_i - BASE_ADDR;
  assign in_range = (sys_addr_i >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign req_any  = sys_wen_i | sys_ren_i;
  assign idx_in   = off[LOG2_SW +: IW];
  assign unused_ok = ^off;

  always_comb begin
    op_in = OP_RD;
    if ((sys_wen_i && sys_ren_i) || !in_range) op_in = OP_ERR;
    else if (sys_wen_i)                        op_in = OP_WR;
  end

  // With WAIT_CYC==0 a legal request completes straight from IDLE, before the
  // request register is loaded, so the storage port is fed from the bus inputs
  // in IDLE and from the request register otherwise.
  op_e           cur_op;
  logic [IW-1:0] cur_idx;
  logic [DW-1:0] cur_wdata;
  logic [SW-1:0] cur_sel;

  always_comb begin
    cur_op    = req_op_q;
    cur_idx   = req_idx_q;
    cur_wdata = req_wdata_q;
    cur_sel   = req_sel_q;
    if (state_q == ST_IDLE) begin
      cur_op    = op_in;
      cur_idx   = idx_in;
      cur_wdata = sys_wdata_i;
      cur_sel   = sys_sel_i;
    end
  end

  // High on the edge that raises sys_ack_o; gated by reset so a pending
  // request is discarded without touching storage.
  logic resp_fire;
  assign resp_fire = !sys_rst_i && (
      (state_q == ST_IDLE && req_any && (op_in == OP_ERR || WAIT_CYC == 0)) ||
      (state_q == ST_WAIT && !stall_i && wcnt_q == WCNT_W'(1)));

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q     <= ST_IDLE;
      req_op_q    <= OP_RD;
      req_idx_q   <= '0;
      req_wdata_q <= '0;
      req_sel_q   <= '0;
      wcnt_q      <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      ack_q <= resp_fire;
      err_q <= resp_fire && (cur_op == OP_ERR);

      if (state_q != ST_IDLE && req_any && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            req_op_q    <= op_in;
            req_idx_q   <= idx_in;
            req_wdata_q <= sys_wdata_i;
            req_sel_q   <= sys_sel_i;
            if (resp_fire) begin
              state_q <= ST_RESP;
            end else begin
              wcnt_q  <= WCNT_W'(WAIT_CYC);
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!stall_i) begin
            wcnt_q <= wcnt_q - WCNT_W'(1);
            if (wcnt_q == WCNT_W'(1)) state_q <= ST_RESP;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sys_bus_mem_array #(
    .DW    (DW),
    .SW    (SW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk   (sys_clk_i),
    .rst   (sys_rst_i),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .be    (cur_sel),
    .we    (resp_fire && cur_op == OP_WR),
    .re    (resp_fire && cur_op == OP_RD),
    .clr   (resp_fire && cur_op == OP_ERR),
    .rdata (sys_rdata_o)
  );

  assign sys_ack_o  = ack_q;
  assign sys_err_o  = err_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign drop_cnt_o = drop_q;

endmodule
